// File: rtl/display_pkg.sv
// Shared display timing defaults for the 640x480 60 Hz mode.
// Other timing variants can define their own set alongside these.
package display_pkg;

   localparam int CORDW_DEF = 10;

   localparam int H_ACTIVE_480P = 640;
   localparam int H_FRONT_480P  = 16;
   localparam int H_SYNC_480P   = 96;
   localparam int H_BACK_480P   = 48;

   localparam int V_ACTIVE_480P = 480;
   localparam int V_FRONT_480P  = 10;
   localparam int V_SYNC_480P   = 2;
   localparam int V_BACK_480P   = 33;

endpackage

// File: rtl/display_counter.sv
// Free-running wrap counter: counts 0..MAX while enabled, then returns to 0.
// Used for both the horizontal (pixel) and vertical (line) positions.
module display_counter #(
   parameter int           W   = 10,
   parameter logic [W-1:0] MAX = '1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_en,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= (r_count == MAX) ? '0 : r_count + W'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/simple_480p.sv
// 640x480 display timing generator: pixel/line counters plus zero-latency
// sync, data-enable and start-of-line/frame decodes.
module simple_480p
   import display_pkg::*;
#(
   parameter int CORDW    = CORDW_DEF,
   parameter int H_ACTIVE = H_ACTIVE_480P,
   parameter int H_FRONT  = H_FRONT_480P,
   parameter int H_SYNC   = H_SYNC_480P,
   parameter int H_BACK   = H_BACK_480P,
   parameter int V_ACTIVE = V_ACTIVE_480P,
   parameter int V_FRONT  = V_FRONT_480P,
   parameter int V_SYNC   = V_SYNC_480P,
   parameter int V_BACK   = V_BACK_480P
) (
   input  logic             clk_pix,
   input  logic             rst_pix,
   output logic [CORDW-1:0] sx,
   output logic [CORDW-1:0] sy,
   output logic             hsync,
   output logic             vsync,
   output logic             de,
   output logic             frame,
   output logic             line
);

   localparam logic [CORDW-1:0] HA_END = CORDW'(H_ACTIVE - 1);
   localparam logic [CORDW-1:0] HS_STA = CORDW'(H_ACTIVE - 1 + H_FRONT);
   localparam logic [CORDW-1:0] HS_END = CORDW'(H_ACTIVE - 1 + H_FRONT + H_SYNC);
   localparam logic [CORDW-1:0] LINE   = CORDW'(H_ACTIVE - 1 + H_FRONT + H_SYNC + H_BACK);

   localparam logic [CORDW-1:0] VA_END = CORDW'(V_ACTIVE - 1);
   localparam logic [CORDW-1:0] VS_STA = CORDW'(V_ACTIVE - 1 + V_FRONT);
   localparam logic [CORDW-1:0] VS_END = CORDW'(V_ACTIVE - 1 + V_FRONT + V_SYNC);
   localparam logic [CORDW-1:0] SCREEN = CORDW'(V_ACTIVE - 1 + V_FRONT + V_SYNC + V_BACK);

   logic             w_lineEnd;
   logic [CORDW-1:0] w_sx;
   logic [CORDW-1:0] w_sy;

   // The vertical counter only advances on the cycle the horizontal one wraps.
   assign w_lineEnd = (w_sx == LINE);

   display_counter #(.W(CORDW), .MAX(LINE)) u_hCounter (
      .clk     (clk_pix),
      .rst     (rst_pix),
      .i_en    (1'b1),
      .o_count (w_sx)
   );

   display_counter #(.W(CORDW), .MAX(SCREEN)) u_vCounter (
      .clk     (clk_pix),
      .rst     (rst_pix),
      .i_en    (w_lineEnd),
      .o_count (w_sy)
   );

   // Decodes are left combinational; the parent registers them with its colour data.
   assign sx    = w_sx;
   assign sy    = w_sy;
   assign hsync = ~((w_sx >= HS_STA) && (w_sx < HS_END));
   assign vsync = ~((w_sy >= VS_STA) && (w_sy < VS_END));
   assign de    = (w_sx <= HA_END) && (w_sy <= VA_END);
   assign line  = (w_sx == '0);
   assign frame = (w_sx == '0) && (w_sy == '0);

endmodule

// File: tb/tb_simple_480p.sv
// Directed bench: a default-timing instance checks horizontal behaviour at 480p,
// a shrunken-timing instance makes full-frame checks affordable.
module tb_simple_480p;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   logic [9:0] sx, sy;
   logic       hsync, vsync, de, frame, line;

   simple_480p dut (
      .clk_pix (clk), .rst_pix (rst),
      .sx (sx), .sy (sy), .hsync (hsync), .vsync (vsync),
      .de (de), .frame (frame), .line (line)
   );

   // Small timing: HA_END=15 HS_STA=19 HS_END=25 LINE=31; VA_END=11 VS_STA=13 VS_END=15 SCREEN=19
   logic [9:0] sSx, sSy;
   logic       sHsync, sVsync, sDe, sFrame, sLine;

   simple_480p #(
      .CORDW (10),
      .H_ACTIVE (16), .H_FRONT (4), .H_SYNC (6), .H_BACK (6),
      .V_ACTIVE (12), .V_FRONT (2), .V_SYNC (2), .V_BACK (4)
   ) dutSmall (
      .clk_pix (clk), .rst_pix (rst),
      .sx (sSx), .sy (sSy), .hsync (sHsync), .vsync (sVsync),
      .de (sDe), .frame (sFrame), .line (sLine)
   );

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tests++;
         if (sx !== 10'd0 || sy !== 10'd0 || de !== 1'b1 || hsync !== 1'b1 ||
             vsync !== 1'b1 || line !== 1'b1 || frame !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_hold cycle %0d: sx=%0d sy=%0d de=%b hs=%b vs=%b ln=%b fr=%b, required 0 0 1 1 1 1 1",
                     i, sx, sy, de, hsync, vsync, line, frame);
         end
      end
      rst = 1'b0;
      @(negedge clk);
      tests++;
      if (sx !== 10'd1 || sy !== 10'd0) begin
         failures++;
         $display("[TB] FAIL reset_release: sx=%0d sy=%0d, required 1 0", sx, sy);
      end
      tests++;
      if (sSx !== 10'd1 || sSy !== 10'd0) begin
         failures++;
         $display("[TB] FAIL reset_release_small: sx=%0d sy=%0d, required 1 0", sSx, sSy);
      end
   endtask

   task automatic test_line_wrap();
      int n = 0;
      while (sx !== 10'd799 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (sx !== 10'd799 || sy !== 10'd0 || de !== 1'b0 || line !== 1'b0) begin
         failures++;
         $display("[TB] FAIL line_end: sx=%0d sy=%0d de=%b ln=%b after %0d cycles, required 799 0 0 0",
                  sx, sy, de, line, n);
      end
      @(negedge clk);
      tests++;
      if (sx !== 10'd0 || sy !== 10'd1 || line !== 1'b1 || frame !== 1'b0 || de !== 1'b1) begin
         failures++;
         $display("[TB] FAIL line_wrap: sx=%0d sy=%0d ln=%b fr=%b de=%b, required 0 1 1 0 1",
                  sx, sy, line, frame, de);
      end
   endtask

   // Starts at (0,1) and walks exactly one full line.
   task automatic test_hsync();
      int lowCount = 0;
      int firstLow = -1;
      for (int i = 0; i < 800; i++) begin
         if (hsync === 1'b0) begin
            if (firstLow < 0) firstLow = int'(sx);
            lowCount++;
         end
         @(negedge clk);
      end
      tests++;
      if (lowCount != 96) begin
         failures++;
         $display("[TB] FAIL hsync_width: got %0d low cycles, required 96", lowCount);
      end
      tests++;
      if (firstLow != 655) begin
         failures++;
         $display("[TB] FAIL hsync_start: first low at sx=%0d, required 655", firstLow);
      end
      tests++;
      if (sx !== 10'd0 || sy !== 10'd2) begin
         failures++;
         $display("[TB] FAIL line_period: sx=%0d sy=%0d, required 0 2", sx, sy);
      end
   endtask

   task automatic test_frame_wrap();
      int n = 0;
      while (!(sSx === 10'd31 && sSy === 10'd19) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (sSx !== 10'd31 || sSy !== 10'd19 || sDe !== 1'b0 || sVsync !== 1'b1) begin
         failures++;
         $display("[TB] FAIL frame_end: sx=%0d sy=%0d de=%b vs=%b after %0d cycles, required 31 19 0 1",
                  sSx, sSy, sDe, sVsync, n);
      end
      @(negedge clk);
      tests++;
      if (sSx !== 10'd0 || sSy !== 10'd0 || sFrame !== 1'b1 || sLine !== 1'b1 || sDe !== 1'b1) begin
         failures++;
         $display("[TB] FAIL frame_wrap: sx=%0d sy=%0d fr=%b ln=%b de=%b, required 0 0 1 1 1",
                  sSx, sSy, sFrame, sLine, sDe);
      end
   endtask

   // Starts at (0,0) of the small instance and walks one whole 640-cycle frame.
   task automatic test_frame_stats();
      int deCount = 0;
      int hsLow = 0;
      int vsLines = 0;
      int vsFirst = -1;
      int frameCount = 0;
      for (int i = 0; i < 640; i++) begin
         if (sDe === 1'b1) deCount++;
         if (sHsync === 1'b0) hsLow++;
         if (sFrame === 1'b1) frameCount++;
         if (sVsync === 1'b0 && sSx === 10'd0) begin
            if (vsFirst < 0) vsFirst = int'(sSy);
            vsLines++;
         end
         if ((sSx === 10'd16 && sSy === 10'd0) || (sSx === 10'd0 && sSy === 10'd12)) begin
            tests++;
            if (sDe !== 1'b0) begin
               failures++;
               $display("[TB] FAIL de_edge at (%0d,%0d): de=%b, required 0", sSx, sSy, sDe);
            end
         end
         @(negedge clk);
      end
      tests++;
      if (deCount != 192) begin
         failures++;
         $display("[TB] FAIL de_count: got %0d, required 192", deCount);
      end
      tests++;
      if (hsLow != 120) begin
         failures++;
         $display("[TB] FAIL hsync_frame: got %0d low cycles, required 120", hsLow);
      end
      tests++;
      if (vsLines != 2 || vsFirst != 13) begin
         failures++;
         $display("[TB] FAIL vsync_lines: got %0d lines from sy=%0d, required 2 from 13", vsLines, vsFirst);
      end
      tests++;
      if (frameCount != 1) begin
         failures++;
         $display("[TB] FAIL frame_pulses: got %0d, required 1", frameCount);
      end
      tests++;
      if (sSx !== 10'd0 || sSy !== 10'd0 || sFrame !== 1'b1) begin
         failures++;
         $display("[TB] FAIL frame_period: sx=%0d sy=%0d fr=%b, required 0 0 1", sSx, sSy, sFrame);
      end
   endtask

   task automatic test_mid_reset();
      int n = 0;
      while (!(sSx === 10'd10 && sSy === 10'd5) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (sSx !== 10'd10 || sSy !== 10'd5) begin
         failures++;
         $display("[TB] FAIL mid_reach: sx=%0d sy=%0d after %0d cycles, required 10 5", sSx, sSy, n);
      end
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         tests++;
         if (sSx !== 10'd0 || sSy !== 10'd0 || sFrame !== 1'b1 || sx !== 10'd0 || sy !== 10'd0) begin
            failures++;
            $display("[TB] FAIL mid_reset cycle %0d: small=(%0d,%0d) fr=%b big=(%0d,%0d), required (0,0) 1 (0,0)",
                     i, sSx, sSy, sFrame, sx, sy);
         end
      end
      rst = 1'b0;
      @(negedge clk);
      tests++;
      if (sSx !== 10'd1 || sSy !== 10'd0) begin
         failures++;
         $display("[TB] FAIL mid_release: sx=%0d sy=%0d, required 1 0", sSx, sSy);
      end
      repeat (5) @(negedge clk);
      tests++;
      if (sSx !== 10'd6 || sSy !== 10'd0 || sx !== 10'd6) begin
         failures++;
         $display("[TB] FAIL mid_resume: small=(%0d,%0d) big sx=%0d, required (6,0) 6", sSx, sSy, sx);
      end
   endtask

   initial begin
      test_reset();
      test_line_wrap();
      test_hsync();
      test_frame_wrap();
      test_frame_stats();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
